// File: rtl/scanline_fx.sv
// Scanline attenuation effect: per-line brightness levels from a repeating pattern, fixed-latency pipeline.
// Optional macro SCANLINE_FIELD_TOGGLE_EN offsets the pattern by one line on alternate frames.
module scanline_fx #(
  parameter int COLOR_W    = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             pattern,
  input  logic [1:0]             period,
  input  logic [3*COLOR_W-1:0]   din,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   de_in,
  input  logic                   ce_in,
  output logic [3*COLOR_W-1:0]   dout,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   de_out,
  output logic                   ce_out
);

  localparam int PW = 3*COLOR_W + 4;

  logic           hs_q, hs_d, vs_q, vs_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     shadow_pattern_q, shadow_pattern_d;
  logic [1:0]     shadow_period_q, shadow_period_d;
  logic           hs_fall, vs_fall;
  logic [1:0]     eff_idx, level;
  logic [3*COLOR_W-1:0] att;
  logic [PW-1:0]  pipe_q [PIPE_DEPTH];
  logic [PW-1:0]  pipe_d [PIPE_DEPTH];
`ifdef SCANLINE_FIELD_TOGGLE_EN
  logic           field_q, field_d;
  logic [2:0]     idx_sum;
`endif

  function automatic logic [COLOR_W-1:0] atten(input logic [COLOR_W-1:0] x, input logic [1:0] lv);
    case (lv)
      2'd0:    return x;
      2'd1:    return (x >> 1) + (x >> 2);
      2'd2:    return x >> 1;
      default: return x >> 2;
    endcase
  endfunction

  always_comb begin
    hs_fall = hs_q & ~hs_in;
    vs_fall = vs_q & ~vs_in;
    hs_d = hs_in;
    vs_d = vs_in;
    shadow_pattern_d = shadow_pattern_q;
    shadow_period_d  = shadow_period_q;
    idx_d = idx_q;
    // vsync wins over a coincident hsync so every frame starts on line 0
    if (vs_fall) begin
      idx_d            = 2'd0;
      shadow_pattern_d = pattern;
      shadow_period_d  = period;
    end else if (hs_fall) begin
      idx_d = (idx_q == shadow_period_q) ? 2'd0 : idx_q + 2'd1;
    end
`ifdef SCANLINE_FIELD_TOGGLE_EN
    field_d = vs_fall ? ~field_q : field_q;
    idx_sum = {1'b0, idx_q} + {2'b00, field_q};
    eff_idx = (idx_sum > {1'b0, shadow_period_q}) ? 2'd0 : idx_sum[1:0];
`else
    eff_idx = idx_q;
`endif
  end

  always_comb begin
    level = shadow_pattern_q[{eff_idx, 1'b0} +: 2];
    att = {atten(din[3*COLOR_W-1 -: COLOR_W], level),
           atten(din[2*COLOR_W-1 -: COLOR_W], level),
           atten(din[COLOR_W-1   -: COLOR_W], level)};
    pipe_d[0] = {hs_in, vs_in, de_in, ce_in, att};
    for (int i = 1; i < PIPE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q             <= 1'b0;
      vs_q             <= 1'b0;
      idx_q            <= 2'd0;
      shadow_pattern_q <= 8'd0;
      shadow_period_q  <= 2'd0;
`ifdef SCANLINE_FIELD_TOGGLE_EN
      field_q          <= 1'b0;
`endif
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      hs_q             <= hs_d;
      vs_q             <= vs_d;
      idx_q            <= idx_d;
      shadow_pattern_q <= shadow_pattern_d;
      shadow_period_q  <= shadow_period_d;
`ifdef SCANLINE_FIELD_TOGGLE_EN
      field_q          <= field_d;
`endif
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign {hs_out, vs_out, de_out, ce_out, dout} = pipe_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_scanline_fx.sv
// Directed bench for scanline_fx: frame-level reference model checked every cycle plus literal pixel pins.
module tb_scanline_fx;
  localparam int CW = 8;
  localparam int D  = 3;
  localparam int PW = 3*CW + 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      pattern;
  logic [1:0]      period;
  logic [3*CW-1:0] din, dout;
  logic            hs_in, vs_in, de_in, ce_in;
  logic            hs_out, vs_out, de_out, ce_out;

  int checks = 0;
  int errors = 0;

  scanline_fx #(.COLOR_W(CW), .PIPE_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .pattern(pattern), .period(period), .din(din),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .ce_in(ce_in),
    .dout(dout), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .ce_out(ce_out)
  );

  always #5 clk = ~clk;

  // Reference: counts lines since the last frame start; level index is that count modulo pattern length.
  logic [PW-1:0] exp_q[$];
  bit  prev_hs, prev_vs;
  int  line_no, frames;
  int  sh_pat, sh_per;

  function automatic int shade(input int x, input int lv);
    if (lv == 0) return x;
    if (lv == 1) return x/2 + x/4;
    if (lv == 2) return x/2;
    return x/4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_hs = 0; prev_vs = 0; line_no = 0; frames = 0; sh_pat = 0; sh_per = 0;
      exp_q.delete();
      repeat (D) exp_q.push_back('0);
    end else begin
      int eff, lv, r, g, b;
      eff = line_no;
`ifdef SCANLINE_FIELD_TOGGLE_EN
      eff = eff + (frames % 2);
`endif
      eff = eff % (sh_per + 1);
      lv  = (sh_pat >> (2*eff)) % 4;
      r = shade(int'(din[23:16]), lv);
      g = shade(int'(din[15:8]), lv);
      b = shade(int'(din[7:0]), lv);
      exp_q.push_back({hs_in, vs_in, de_in, ce_in, r[7:0], g[7:0], b[7:0]});
      void'(exp_q.pop_front());
      if (prev_vs && !vs_in) begin
        line_no = 0; frames++; sh_pat = int'(pattern); sh_per = int'(period);
      end else if (prev_hs && !hs_in) begin
        line_no++;
      end
      prev_hs = hs_in; prev_vs = vs_in;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() == D) begin
      checks++;
      if ({hs_out, vs_out, de_out, ce_out, dout} !== exp_q[0]) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time,
                 {hs_out, vs_out, de_out, ce_out, dout}, exp_q[0]);
      end
    end
  end

  task automatic pin(input string name, input logic [27:0] act, input logic [27:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Pixels first, then an hsync pulse whose falling edge starts the next line.
  task automatic line(input logic [23:0] v, input logic [23:0] exp_v);
    for (int i = 0; i < 6; i++) begin
      din = v; de_in = 1'b1; ce_in = (i % 2 == 0);
      tick(1);
      if (i == D-1) pin("line_px", {4'h0, dout}, {4'h0, exp_v});
    end
    de_in = 1'b0; ce_in = 1'b1; din = 24'h102030; hs_in = 1'b1;
    tick(2);
    hs_in = 1'b0;
    tick(2);
  endtask

  // hsync and vsync fall in the same clock.
  task automatic vsync();
    de_in = 1'b0; vs_in = 1'b1; hs_in = 1'b1;
    tick(2);
    vs_in = 1'b0; hs_in = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b0; pattern = 8'h00; period = 2'd0; din = '0;
    hs_in = 0; vs_in = 0; de_in = 0; ce_in = 0;
    #2 reset = 1'b1;
    tick(3);
    pin("reset_out", {hs_out, vs_out, de_out, ce_out, dout}, 28'h0);
    reset = 1'b0;
    tick(2);

`ifdef SCANLINE_FIELD_TOGGLE_EN
    pattern = 8'b0000_1000; period = 2'd1;
    vsync();
    line(24'hFFFFFF, 24'h7F7F7F);
    line(24'hFFFFFF, 24'hFFFFFF);
    vsync();
    line(24'hFFFFFF, 24'hFFFFFF);
    line(24'hFFFFFF, 24'h7F7F7F);
`else
    pattern = 8'b0000_1000; period = 2'd1;
    line(24'hFFFFFF, 24'hFFFFFF);
    vsync();
    line(24'hFFFFFF, 24'hFFFFFF);
    line(24'hFFFFFF, 24'h7F7F7F);
    line(24'hFFFFFF, 24'hFFFFFF);
    line(24'hFFFFFF, 24'h7F7F7F);

    pattern = 8'b00_11_01_00; period = 2'd2;
    vsync();
    line(24'hC86404, 24'hC86404);
    line(24'hC86404, 24'h964B03);
    line(24'hC86404, 24'h321901);
    line(24'hC86404, 24'hC86404);
    line(24'hC86404, 24'h964B03);
    line(24'hC86404, 24'h321901);
    line(24'hC86404, 24'hC86404);

    pattern = 8'h00; period = 2'd0;
    vsync();
    line(24'hC86404, 24'hC86404);
    pattern = 8'hFF;
    line(24'hC86404, 24'hC86404);
    line(24'hC86404, 24'hC86404);
    vsync();
    line(24'hC86404, 24'h321901);
    line(24'hC86404, 24'h321901);
`endif

    din = 24'hC86404; de_in = 1'b1; ce_in = 1'b1;
    tick(5);
    reset = 1'b1;
    #1 pin("reset_now", {hs_out, vs_out, de_out, ce_out, dout}, 28'h0);
    tick(2);
    reset = 1'b0;
    din = 24'hABCDEF;
    tick(D-1);
    pin("post_rst_gap", {4'h0, dout}, 28'h0);
    tick(1);
    pin("post_rst_px", {4'h0, dout}, {4'h0, 24'hABCDEF});
    line(24'hABCDEF, 24'hABCDEF);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
